// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - 256x16 instruction memory with default program, async reset and load port
module inst_rom #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [INST_WIDTH-1:0] inst,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  // Boot program: counts R1 from 1 to 10, storing each to 0x10, then parks at 0x08.
  function automatic logic [INST_WIDTH-1:0] default_word(input logic [ADDR_WIDTH-1:0] a);
    logic [INST_WIDTH-1:0] w;
    w = '0;
    case (a)
      ADDR_WIDTH'(8'h00): w = INST_WIDTH'(16'h3100);
      ADDR_WIDTH'(8'h01): w = INST_WIDTH'(16'h3201);
      ADDR_WIDTH'(8'h02): w = INST_WIDTH'(16'h3310);
      ADDR_WIDTH'(8'h03): w = INST_WIDTH'(16'h8112);
      ADDR_WIDTH'(8'h04): w = INST_WIDTH'(16'h2130);
      ADDR_WIDTH'(8'h05): w = INST_WIDTH'(16'h1430);
      ADDR_WIDTH'(8'h06): w = INST_WIDTH'(16'h610A);
      ADDR_WIDTH'(8'h07): w = INST_WIDTH'(16'h3003);
      ADDR_WIDTH'(8'h08): w = INST_WIDTH'(16'h3008);
      default:            w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_word(ADDR_WIDTH'(i));
      end
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign inst = mem[address];

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - self-checking bench for inst_rom: vector table, random model, CPU program run
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b1;
  logic [7:0]  address = '0;
  logic [15:0] inst;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;

  int errors = 0;
  int checks = 0;

  inst_rom #(.ADDR_WIDTH(8), .INST_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .address(address), .inst(inst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct { logic [7:0] addr; logic [15:0] exp; } vec_t;
  vec_t vecs [12];

  logic [15:0] dflt [256];
  logic [15:0] ref_mem [256];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = dflt[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Small program-level interpreter used to execute the boot program out of the DUT.
  logic [7:0] r [16];
  logic [7:0] dmem [256];
  logic [7:0] stores [$];

  task automatic run_cpu(input int cycles);
    logic [15:0] ins;
    logic [3:0] op, d, a1, a2;
    logic [7:0] next_pc, ea;
    for (int i = 0; i < 16; i++) r[i] = '0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    stores.delete();
    for (int c = 0; c < cycles; c++) begin
      address = r[0];
      #1;
      ins = inst;
      op = ins[15:12]; d = ins[11:8]; a1 = ins[7:4]; a2 = ins[3:0];
      next_pc = r[0] + 8'd1;
      ea = r[a1] + {4'd0, a2};
      case (op)
        4'h3: begin
          if (d == 4'd0) next_pc = ins[7:0];
          else r[d] = ins[7:0];
        end
        4'h8: begin
          if (d == 4'd0) next_pc = r[a1] + r[a2];
          else r[d] = r[a1] + r[a2];
        end
        4'h2: begin dmem[ea] = r[d]; if (ea == 8'h10) stores.push_back(r[d]); end
        4'h1: if (d != 4'd0) r[d] = dmem[ea];
        4'h6: if (r[d] == ins[7:0]) next_pc = next_pc + 8'd1;
        default: ;
      endcase
      r[0] = next_pc;
    end
    address = r[0];
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dflt[i] = 16'h0000;
    dflt[0] = 16'h3100; dflt[1] = 16'h3201; dflt[2] = 16'h3310;
    dflt[3] = 16'h8112; dflt[4] = 16'h2130; dflt[5] = 16'h1430;
    dflt[6] = 16'h610A; dflt[7] = 16'h3003; dflt[8] = 16'h3008;

    vecs[0]  = '{8'h00, 16'h3100}; vecs[1]  = '{8'h01, 16'h3201};
    vecs[2]  = '{8'h02, 16'h3310}; vecs[3]  = '{8'h03, 16'h8112};
    vecs[4]  = '{8'h04, 16'h2130}; vecs[5]  = '{8'h05, 16'h1430};
    vecs[6]  = '{8'h06, 16'h610A}; vecs[7]  = '{8'h07, 16'h3003};
    vecs[8]  = '{8'h08, 16'h3008}; vecs[9]  = '{8'h09, 16'h0000};
    vecs[10] = '{8'h80, 16'h0000}; vecs[11] = '{8'hFF, 16'h0000};

    // Reset with no clock edge required
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("reset_addr0", inst, 16'h3100);
    tick();
    rst = 1'b1;

    foreach (vecs[i]) begin
      address = vecs[i].addr;
      #1;
      check($sformatf("default_%02h", vecs[i].addr), inst, vecs[i].exp);
    end
    for (int a = 9; a < 256; a++) begin
      address = 8'(a);
      #1;
      if (inst !== 16'h0000) check($sformatf("nop_%02h", a), inst, 16'h0000);
    end
    checks++;

    // Write with concurrent read of the same address
    tick();
    address = 8'h20; prog_we = 1'b1; prog_addr = 8'h20; prog_data = 16'hABCD;
    #1;
    check("rw_before_edge", inst, 16'h0000);
    tick();
    prog_we = 1'b0;
    ref_mem[8'h20] = 16'hABCD;
    check("rw_after_edge", inst, 16'hABCD);
    address = 8'h1F; #1; check("neighbor_1f", inst, 16'h0000);
    address = 8'h21; #1; check("neighbor_21", inst, 16'h0000);

    // Overwrite word 0 then reset between edges
    prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'hF000; address = 8'h00;
    tick();
    prog_we = 1'b0;
    check("overwrite_0", inst, 16'hF000);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_reset_restore", inst, 16'h3100);
    address = 8'h20; #1;
    check("reset_clears_20", inst, 16'h0000);

    // Writes held across reset edges are discarded
    prog_we = 1'b1; prog_addr = 8'h05; prog_data = 16'h1234;
    tick();
    tick();
    prog_we = 1'b0;
    rst = 1'b1;
    address = 8'h05; #1;
    check("write_during_reset", inst, 16'h1430);

    // First edge after release takes a write
    prog_we = 1'b1; prog_addr = 8'h05; prog_data = 16'h5A5A;
    tick();
    prog_we = 1'b0;
    ref_mem[8'h05] = 16'h5A5A;
    check("first_write_after_release", inst, 16'h5A5A);

    // Random load traffic against an array model, with occasional resets
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [7:0]  pa;
      logic [15:0] pd;
      we = 1'($urandom_range(0, 1));
      pa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      pd = 16'($urandom);
      prog_we = we; prog_addr = pa; prog_data = pd;
      address = (n % 2 == 0) ? pa : 8'($urandom);
      #1;
      check("rand_pre_edge", inst, ref_mem[address]);
      if (n % 37 == 36) begin
        rst = 1'b0;
        #1;
        model_reset();
        check("rand_async_reset", inst, ref_mem[address]);
        tick();
        rst = 1'b1;
      end else begin
        tick();
        if (we) ref_mem[pa] = pd;
      end
      prog_we = 1'b0;
      check("rand_post_edge", inst, ref_mem[address]);
      check("rand_no_x", {15'd0, $isunknown(inst)}, 16'd0);
    end

    // Combinational tracking with the clock stopped
    clk_en = 1'b0;
    #20;
    for (int k = 0; k < 8; k++) begin
      address = 8'($urandom);
      #0;
      #1;
      check("no_clock_track", inst, ref_mem[address]);
    end

    // Restore defaults and run the boot program
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
    #1;
    run_cpu(60);
    check("cpu_store_count", 16'(stores.size()), 16'd10);
    for (int i = 0; i < stores.size() && i < 10; i++)
      check($sformatf("cpu_store_%0d", i), {8'd0, stores[i]}, 16'(i + 1));
    check("cpu_r1_final", {8'd0, r[1]}, 16'h000A);
    check("cpu_pc_final", {8'd0, r[0]}, 16'h0008);
    check("cpu_inst_final", inst, 16'h3008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
